// File: rtl/dice_roller.sv
// Electronic die: a free-running 23-bit LFSR is sampled on each roll request.
// Candidates at or above LIMIT are rejected and resampled; after MAX_TRIES
// rejections the last candidate is folded down by LIMIT so a roll always ends.
module dice_roller #(
  parameter int unsigned N         = 23,
  parameter logic [22:0] SEED      = 23'h000001,
  parameter int unsigned LIMIT     = 46656,
  parameter int unsigned MAX_TRIES = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         roll,
  output logic [N-1:0] d,
  output logic         valid,
  output logic         busy
);

  localparam int unsigned     TRY_W    = $clog2(MAX_TRIES + 1);
  localparam logic [TRY_W-1:0] LAST_TRY = TRY_W'(MAX_TRIES - 1);
  localparam logic [16:0]     LIMIT_17 = 17'(LIMIT);
  localparam logic [15:0]     LIMIT_16 = 16'(LIMIT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SAMPLE = 2'd1,
    DONE   = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [22:0]        lfsr_q, lfsr_d;
  logic [TRY_W-1:0]   tries_q, tries_d;
  logic [15:0]        d_q, d_d;
  logic               roll_q;
  logic               roll_edge;
  logic [15:0]        cand;

  assign roll_edge = roll & ~roll_q;
  assign cand      = lfsr_q[15:0];

  // LFSR next value; an all-zero register (lock-up) is recovered by reloading SEED.
  always_comb begin
    if (lfsr_q == '0) begin
      lfsr_d = SEED;
    end else begin
      lfsr_d = {lfsr_q[21:0], lfsr_q[22] ^ lfsr_q[17]};
    end
  end

  // Roll FSM next-state: start on a roll edge, accept/reject/fold in SAMPLE.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a variable unassigned and infer a latch.
    state_d = state_q;
    tries_d = tries_q;
    d_d     = d_q;
    unique case (state_q)
      IDLE: begin
        if (roll_edge) begin
          state_d = SAMPLE;
          tries_d = '0;
        end
      end
      SAMPLE: begin
        if ({1'b0, cand} < LIMIT_17) begin
          d_d     = cand;
          state_d = DONE;
        end else if (tries_q == LAST_TRY) begin
          d_d     = cand - LIMIT_16;
          state_d = DONE;
        end else begin
          tries_d = tries_q + TRY_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous reset taking priority over everything.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (reset) begin
      // NOTE: the design holds only a handful of flops, so all of them are
      // reset; nothing here is a memory array that could be left unreset.
      state_q <= IDLE;
      lfsr_q  <= SEED;
      tries_q <= '0;
      d_q     <= '0;
      roll_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      tries_q <= tries_d;
      d_q     <= d_d;
      roll_q  <= roll;
    end
  end

  assign d     = N'(d_q);
  assign valid = (state_q == DONE);
  assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_dice_roller.sv
// Self-checking bench for dice_roller: a directed cycle table, hand-computed
// long-rejection and fold sequences, hold-high behaviour and a long run of
// back-to-back rolls against a reference LFSR model.
module tb_dice_roller;

  logic        clk = 1'b0;
  logic        reset;
  logic        roll, roll_b, roll_c;
  logic [22:0] d, d_b, d_c;
  logic        valid, valid_b, valid_c;
  logic        busy, busy_b, busy_c;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  dice_roller dut (
    .clk(clk), .reset(reset), .roll(roll), .d(d), .valid(valid), .busy(busy)
  );

  dice_roller #(.SEED(23'h00FFFF)) dut_b (
    .clk(clk), .reset(reset), .roll(roll_b), .d(d_b), .valid(valid_b), .busy(busy_b)
  );

  dice_roller #(.SEED(23'h00FFFF), .MAX_TRIES(4)) dut_c (
    .clk(clk), .reset(reset), .roll(roll_c), .d(d_c), .valid(valid_c), .busy(busy_c)
  );

  function automatic logic [22:0] adv(input logic [22:0] x, input logic [22:0] seed);
    return (x == 23'd0) ? seed : {x[21:0], x[22] ^ x[17]};
  endfunction

  // Reference LFSR for the default instance, updated on the same edges.
  logic [22:0] m_lfsr;
  always @(posedge clk) m_lfsr <= reset ? 23'h000001 : adv(m_lfsr, 23'h000001);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Expected result and edge-to-valid latency for a roll whose edge sees lfsr l0.
  task automatic predict(input logic [22:0] l0, output int exp_d, output int exp_lat);
    logic [22:0] x;
    x = l0;
    exp_d = 0;
    exp_lat = 0;
    for (int j = 0; j < 16; j++) begin
      x = adv(x, 23'h000001);
      if (x[15:0] < 16'd46656) begin
        exp_d = int'(x[15:0]);
        exp_lat = j + 2;
        break;
      end else if (j == 15) begin
        exp_d = int'(x[15:0]) - 46656;
        exp_lat = j + 2;
      end
    end
  endtask

  typedef struct {
    logic rst;
    logic rl;
    logic exp_valid;
    logic exp_busy;
    int   exp_d;
  } vec_t;

  function automatic vec_t mk(logic r, logic rl, logic v, logic b, int dd);
    vec_t t;
    t.rst = r; t.rl = rl; t.exp_valid = v; t.exp_busy = b; t.exp_d = dd;
    return t;
  endfunction

  vec_t tbl[18];

  initial begin
    int nv;
    int e_d, e_lat, waited;
    bit got;

    reset  = 1'b1;
    roll   = 1'b0;
    roll_b = 1'b0;
    roll_c = 1'b0;
    repeat (3) @(posedge clk);

    // Each row: check outputs of the current cycle, then drive inputs for it.
    tbl[0]  = mk(1, 0, 0, 0, 0);
    tbl[1]  = mk(0, 1, 0, 0, 0);   // cycle 0, lfsr=1, edge
    tbl[2]  = mk(0, 1, 0, 1, 0);   // SAMPLE, cand=2 accepted
    tbl[3]  = mk(0, 1, 1, 1, 2);   // DONE
    tbl[4]  = mk(0, 1, 0, 0, 2);   // IDLE, roll still high
    tbl[5]  = mk(0, 0, 0, 0, 2);
    tbl[6]  = mk(0, 1, 0, 0, 2);   // cycle 5, lfsr=32, edge
    tbl[7]  = mk(0, 0, 0, 1, 2);   // SAMPLE, cand=64
    tbl[8]  = mk(0, 0, 1, 1, 64);
    tbl[9]  = mk(0, 1, 0, 0, 64);  // edge
    tbl[10] = mk(1, 1, 0, 1, 64);  // reset during SAMPLE
    tbl[11] = mk(0, 0, 0, 0, 0);
    tbl[12] = mk(0, 0, 0, 0, 0);
    tbl[13] = mk(1, 1, 0, 0, 0);   // reset with roll already high
    tbl[14] = mk(0, 1, 0, 0, 0);   // first post-reset cycle counts as edge
    tbl[15] = mk(0, 1, 0, 1, 0);
    tbl[16] = mk(0, 0, 1, 1, 2);
    tbl[17] = mk(0, 0, 0, 0, 2);

    for (int i = 0; i < 18; i++) begin
      @(posedge clk); #1;
      check($sformatf("tbl%0d_valid", i), 32'(valid), 32'(tbl[i].exp_valid));
      check($sformatf("tbl%0d_busy", i),  32'(busy),  32'(tbl[i].exp_busy));
      check($sformatf("tbl%0d_d", i),     32'(d),     32'(tbl[i].exp_d));
      reset = tbl[i].rst;
      roll  = tbl[i].rl;
    end

    // Roll held high for over 100 cycles: exactly one result.
    nv = 0;
    for (int i = 0; i < 105; i++) begin
      @(posedge clk); #1;
      if (valid) nv++;
      roll = 1'b1;
    end
    check("hold_high_valids", 32'(nv), 32'd1);
    roll = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    nv = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (valid) nv++;
      roll = 1'b1;
    end
    check("reassert_valids", 32'(nv), 32'd1);
    roll = 1'b0;
    repeat (3) begin @(posedge clk); #1; end

    // Long-rejection (dut_b) and fold (dut_c) sequences from SEED 0x00FFFF.
    reset = 1'b1;
    @(posedge clk); #1;
    check("seed_b_lfsr", 32'(dut_b.lfsr_q), 32'h00FFFF);
    reset  = 1'b0;
    roll_b = 1'b1;
    roll_c = 1'b1;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(posedge clk); #1;
      check($sformatf("b_valid_c%0d", cyc), 32'(valid_b), 32'(cyc == 16));
      check($sformatf("b_busy_c%0d", cyc),  32'(busy_b),  32'(cyc <= 16));
      check($sformatf("b_d_c%0d", cyc),     32'(d_b),     (cyc >= 16) ? 32'd40704 : 32'd0);
      check($sformatf("c_valid_c%0d", cyc), 32'(valid_c), 32'(cyc == 5));
      check($sformatf("c_busy_c%0d", cyc),  32'(busy_c),  32'(cyc <= 5));
      check($sformatf("c_d_c%0d", cyc),     32'(d_c),     (cyc >= 5) ? 32'd18867 : 32'd0);
      roll_b = (cyc == 1) || (cyc == 4) || (cyc >= 16 && cyc < 36);
    end
    roll_b = 1'b0;
    roll_c = 1'b0;
    repeat (2) begin @(posedge clk); #1; end

    // Back-to-back rolls on the default instance against the reference model.
    for (int r = 0; r < 10000; r++) begin
      @(posedge clk); #1;
      check("lfsr_model", 32'(dut.lfsr_q), 32'(m_lfsr));
      predict(m_lfsr, e_d, e_lat);
      roll = 1'b1;
      waited = 0;
      got = 1'b0;
      while (!got && waited < 40) begin
        @(posedge clk); #1;
        roll = 1'b0;
        waited++;
        if (valid) got = 1'b1;
      end
      check($sformatf("roll%0d_latency", r), 32'(waited), 32'(e_lat));
      check($sformatf("roll%0d_d", r), 32'(d), 32'(e_d));
      check($sformatf("roll%0d_range", r), 32'(d < 23'd46656), 32'd1);
      @(posedge clk); #1;
      check($sformatf("roll%0d_valid_width", r), 32'({valid, busy}), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/dice_roller.md
DICE_ROLLER -- requirements
Module: dice_roller

Interface
REQ-001 Parameter N, default 23: width of output d; SHALL be >= 16.
REQ-002 Parameter SEED, default 23'h000001: LFSR reset value; SHALL be nonzero.
REQ-003 Parameter LIMIT, default 46656 (6**6): exclusive upper bound of d.
REQ-004 Parameter MAX_TRIES, default 16: SAMPLE cycles allowed before forced fold.
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 roll  input  1  roll request, level, already debounced; a roll starts on its rising edge.
REQ-008 d  output  N  rolled value, 0..LIMIT-1, zero-extended above bit 15; feeds the base-6 digit splitter.
REQ-009 valid  output  1  high for exactly one cycle when a new d is presented.
REQ-010 busy  output  1  high while a roll is in progress (SAMPLE or DONE).

Function
REQ-011 lfsr: 23-bit Fibonacci LFSR; advances every non-reset cycle regardless of state: next = {lfsr[21:0], lfsr[22]^lfsr[17]}.
REQ-012 If lfsr is ever all-zero it SHALL reload SEED on the next edge.
REQ-013 roll_q: registered copy of roll; edge = roll & ~roll_q.
REQ-014 States IDLE, SAMPLE, DONE; binary-encoded, unused encodings go to IDLE.
REQ-015 IDLE: on edge -> SAMPLE, tries <= 0; otherwise stay.
REQ-016 SAMPLE: cand = lfsr[15:0] of the current cycle.
REQ-017 SAMPLE, cand < LIMIT: d <= cand; -> DONE.
REQ-018 SAMPLE, cand >= LIMIT and tries == MAX_TRIES-1: d <= cand - LIMIT (16-bit result, always < LIMIT); -> DONE.
REQ-019 SAMPLE, otherwise: tries <= tries+1; stay in SAMPLE.
REQ-020 DONE: -> IDLE unconditionally.
REQ-021 valid = (state == DONE); busy = (state != IDLE); both decoded from registered state.
REQ-022 d holds its value from one DONE until the next update in SAMPLE.
REQ-023 roll edges arriving in SAMPLE or DONE SHALL be ignored, not queued.
REQ-024 roll held high SHALL produce exactly one roll; it must return low before another roll can start.
REQ-025 Latency, edge in cycle k to valid: minimum k+2; maximum k+1+MAX_TRIES.
REQ-026 d SHALL never be >= LIMIT.

Reset
REQ-027 While reset is high on an edge: state=IDLE, lfsr=SEED, tries=0, roll_q=0, d=0; hence valid=0, busy=0.
REQ-028 reset SHALL take priority over every other transition, including mid-SAMPLE; no valid pulse for an aborted roll.
REQ-029 roll already high when reset falls counts as an edge in the first post-reset cycle.

Verification
- Default params; roll=1 in cycle 0 after reset release (lfsr=1) -> busy=1 in cycle 1 (lfsr=2, accept); cycle 2: valid=1, d=2, busy=1; cycle 3: valid=0, busy=0, d=2.
- roll held high for 100 cycles after the above -> no further valid; release, then reassert -> exactly one new valid.
- SEED=23'h00FFFF, roll at cycle 0 -> cands 65534, 65532, 65529, ... rejected; valid no later than cycle 17; d matches reference LFSR model, including the fold case.
- Pulse roll again during SAMPLE and during DONE -> single valid only; tries not reset.
- Assert reset in the cycle after the edge (SAMPLE) -> next cycle valid=0, busy=0, d=0, lfsr=SEED; no valid until a new edge.
- 10000 back-to-back rolls -> every d < 46656; valid width always 1 cycle; lfsr never zero; every d matches the model.
